led_sweep_engine: RTL and testbench
===================================

Name: led_sweep_engine

Overview:
- Parametrised successor to the single-pattern PMod LED bouncer.
- Drives NLEDS LEDs with per-LED PWM brightness and fading tails.
- Four modes: off, bounce (Knight-Rider), chase (wrap-around) and static host pattern.
- Adds pause and single-step control, plus a step strobe. Sits between a control register block and the PMod LED pins.

Parameters:
NLEDS, 8, LED count (>=2)
NPWM, 7, brightness and PWM counter width; MAX = 2^NPWM-1
CTRBITS, 25, step prescaler width; step period = 2^CTRBITS cycles
TAIL, 4, level a LED clamps to when it loses ownership (0 < TAIL < MAX)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_mode  in  2  00 OFF, 01 BOUNCE, 10 CHASE, 11 STATIC
i_pause  in  1  freeze prescaler; step only via i_step_now
i_step_now  in  1  single-step pulse; honoured only while i_pause=1
i_static  in  NLEDS  on/off map used in STATIC
o_led  out  NLEDS  PWM LED drive
o_owner  out  NLEDS  one-hot current sweep position
o_step  out  1  one-cycle pulse, high in the cycle the new o_owner is visible

Behaviour:
- Reset (sync, wins over all inputs):
  - prescaler=0, pwm counter=0, all levels=0.
  - o_owner=1 (bit 0), dir=UP, o_led=0, o_step=0.
- Prescaler:
  - If !i_pause: increments by 1 every cycle; internal strobe = carry-out (prescaler all-ones wrapping to 0).
  - If i_pause: prescaler held; strobe = i_step_now.
- PWM counter:
  - NPWM bits, free-running and never paused.
  - Compare value br = bit-reverse of the counter.
- Owner FSM (states UP, DOWN), evaluated only on strobe, using i_mode sampled that cycle:
  - BOUNCE, UP: owner==MSB -> dir=DOWN, owner held (one-step dwell); else shift left.
  - BOUNCE, DOWN: owner==bit0 -> dir=UP, owner held; else shift right.
  - CHASE: rotate left (MSB -> bit0); dir forced UP.
  - OFF, STATIC: owner and dir held.
  - Recovery: o_owner==0 in any cycle (not only on strobe) -> next cycle owner=1, dir=UP, regardless of strobe.
- Levels (NPWM bits each):
  - BOUNCE/CHASE, on strobe, per LED k, evaluated against the owner value before the update:
    - owner[k] -> MAX
    - else level>TAIL -> TAIL
    - else level>0 -> level-1
    - else hold
  - STATIC: every cycle, level = i_static[k] ? MAX : 0 (no strobe needed).
  - OFF: every cycle, level=0.
  - Mode switch into BOUNCE/CHASE keeps the current levels; they decay on subsequent strobes.
- Output, registered, one cycle after level:
  - o_led[k] = 1 if level==MAX.
  - o_led[k] = 0 if level==0.
  - Otherwise o_led[k] = (br < level), giving duty = level/2^NPWM over each 2^NPWM-cycle window.
- o_step: registered strobe, asserted the cycle after strobe in BOUNCE/CHASE only.
- Boundaries:
  - i_step_now while !i_pause is ignored.
  - i_pause deasserting resumes the prescaler from its held value.
  - Reset mid-sweep restarts at bit 0 next cycle.

Decomposition:
- Shared package: mode encodings MODE_OFF/MODE_BOUNCE/MODE_CHASE/MODE_STATIC, DIR_UP/DIR_DOWN.
- Sub-module led_pwm_channel, instantiated NLEDS times:
  - Holds one level register and the registered output comparator.
  - Inputs: i_clk, i_reset, strobe, owner bit, mode, static bit, br.
  - Parameters: NPWM, TAIL.
- Top level holds the prescaler, PWM counter and owner FSM.

Test Plan:
1. NLEDS=4, CTRBITS=3, hold i_reset 2 cycles -> o_led=0000, o_owner=0001, o_step=0; first o_step exactly 8 cycles after reset release.
2. BOUNCE: o_owner on successive o_step pulses = 0010,0100,1000,1000,0100,0010,0001,0001,0010.
3. CHASE from owner 0001: o_owner = 0010,0100,1000,0001; dir stays UP.
4. NPWM=7, TAIL=4, BOUNCE: bit-0 level after each strobe = 127,4,3,2,1,0. Measure o_led[0] high count over 128 cycles: 128 at MAX, 3 at level 3, 0 at level 0.
5. i_pause=1 for 100 cycles -> o_owner constant, no o_step. One i_step_now pulse -> exactly one o_step and one position advance. i_step_now with i_pause=0 -> no extra step.
6. STATIC, i_static=1010 -> o_led=1010 within 2 cycles. Then BOUNCE and assert i_reset mid-sweep -> next cycle o_owner=0001, o_led=0000.

Source files
------------

// File: rtl/led_sweep_engine_pkg.sv
// Shared encodings for the LED sweep engine: operating modes and sweep direction.
package led_sweep_engine_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_STATIC = 2'b11
    } mode_t;

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    // Modes in which the sweep position advances and levels decay on each step.
    function automatic logic is_sweep(input mode_t m);
        return (m == MODE_BOUNCE) || (m == MODE_CHASE);
    endfunction

endpackage

// File: rtl/led_sweep_engine_pwm.sv
// One LED channel: brightness level register plus registered PWM comparator.
module led_pwm_channel
    import led_sweep_engine_pkg::*;
#(
    parameter int NPWM = 7,
    parameter int TAIL = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            strobe,
    input  logic            owner,
    input  mode_t           mode,
    input  logic            static_on,
    input  logic [NPWM-1:0] br,
    output logic            led
);

    localparam logic [NPWM-1:0] LVL_MAX  = '1;
    localparam logic [NPWM-1:0] LVL_TAIL = NPWM'(TAIL);

    logic [NPWM-1:0] level;
    logic [NPWM-1:0] level_next;

    // A LED losing ownership snaps to the tail level, then fades one step per strobe.
    always_comb begin
        level_next = level;
        case (mode)
            MODE_OFF:    level_next = '0;
            MODE_STATIC: level_next = static_on ? LVL_MAX : '0;
            MODE_BOUNCE,
            MODE_CHASE: begin
                if (strobe) begin
                    if (owner)
                        level_next = LVL_MAX;
                    else if (level > LVL_TAIL)
                        level_next = LVL_TAIL;
                    else if (level != '0)
                        level_next = level - NPWM'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            level <= '0;
            led   <= 1'b0;
        end else begin
            level <= level_next;
            if (level == LVL_MAX)
                led <= 1'b1;
            else if (level == '0)
                led <= 1'b0;
            else
                led <= (br < level);
        end
    end

endmodule

// File: rtl/led_sweep_engine.sv
// LED sweep engine: step prescaler, free-running PWM counter and owner FSM driving NLEDS channels.
module led_sweep_engine
    import led_sweep_engine_pkg::*;
#(
    parameter int NLEDS   = 8,
    parameter int NPWM    = 7,
    parameter int CTRBITS = 25,
    parameter int TAIL    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_mode,
    input  logic             i_pause,
    input  logic             i_step_now,
    input  logic [NLEDS-1:0] i_static,
    output logic [NLEDS-1:0] o_led,
    output logic [NLEDS-1:0] o_owner,
    output logic             o_step
);

    localparam logic [NLEDS-1:0] OWNER_FIRST = NLEDS'(1);
    localparam logic [NLEDS-1:0] OWNER_LAST  = OWNER_FIRST << (NLEDS - 1);

    mode_t              mode;
    logic [CTRBITS-1:0] presc;
    logic [NPWM-1:0]    pwm_cnt;
    logic [NPWM-1:0]    br;
    logic [NLEDS-1:0]   owner;
    logic [NLEDS-1:0]   owner_next;
    logic [0:0]         dir;
    logic [0:0]         dir_next;
    logic               strobe;
    logic               step_q;

    assign mode = mode_t'(i_mode);
    assign br   = {<<{pwm_cnt}};

    // While paused the prescaler is frozen and only the manual pulse can step.
    always_comb begin
        strobe = i_pause ? i_step_now : (presc == '1);
    end

    // An empty owner register is repaired every cycle, not just on a step.
    always_comb begin
        owner_next = owner;
        dir_next   = dir;
        if (owner == '0) begin
            owner_next = OWNER_FIRST;
            dir_next   = DIR_UP;
        end else if (strobe) begin
            case (mode)
                MODE_BOUNCE: begin
                    if (dir == DIR_UP) begin
                        if (owner == OWNER_LAST)
                            dir_next = DIR_DOWN;
                        else
                            owner_next = owner << 1;
                    end else begin
                        if (owner == OWNER_FIRST)
                            dir_next = DIR_UP;
                        else
                            owner_next = owner >> 1;
                    end
                end
                MODE_CHASE: begin
                    owner_next = {owner[NLEDS-2:0], owner[NLEDS-1]};
                    dir_next   = DIR_UP;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc   <= '0;
            pwm_cnt <= '0;
            owner   <= OWNER_FIRST;
            dir     <= DIR_UP;
            step_q  <= 1'b0;
        end else begin
            if (!i_pause)
                presc <= presc + CTRBITS'(1);
            pwm_cnt <= pwm_cnt + NPWM'(1);
            owner   <= owner_next;
            dir     <= dir_next;
            step_q  <= strobe && is_sweep(mode);
        end
    end

    for (genvar k = 0; k < NLEDS; k++) begin : g_chan
        led_pwm_channel #(
            .NPWM (NPWM),
            .TAIL (TAIL)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .strobe    (strobe),
            .owner     (owner[k]),
            .mode      (mode),
            .static_on (i_static[k]),
            .br        (br),
            .led       (o_led[k])
        );
    end

    assign o_owner = owner;
    assign o_step  = step_q;

endmodule

// File: tb/tb_led_sweep_engine.sv
// Bench for led_sweep_engine: directed scenarios plus randomized traffic against a positional reference model.
module tb_led_sweep_engine;

    localparam int NLEDS   = 4;
    localparam int NPWM    = 7;
    localparam int CTRBITS = 3;
    localparam int TAIL    = 4;
    localparam int MAXL    = (1 << NPWM) - 1;
    localparam int PER     = 1 << CTRBITS;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             pause;
    logic             step_now;
    logic [NLEDS-1:0] stat_map;
    logic [NLEDS-1:0] led;
    logic [NLEDS-1:0] owner;
    logic             step;

    always #5 clk = ~clk;

    led_sweep_engine #(
        .NLEDS   (NLEDS),
        .NPWM    (NPWM),
        .CTRBITS (CTRBITS),
        .TAIL    (TAIL)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_mode     (mode),
        .i_pause    (pause),
        .i_step_now (step_now),
        .i_static   (stat_map),
        .o_led      (led),
        .o_owner    (owner),
        .o_step     (step)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: sweep position as an index, levels as plain integers.
    int             m_presc;
    int             m_pwm;
    int             m_pos;
    bit             m_up;
    int             m_lvl [NLEDS];
    bit [NLEDS-1:0] m_led;
    bit             m_step;

    task automatic model_edge();
        int br;
        bit strobe;
        bit sweep;
        if (rst) begin
            m_presc = 0;
            m_pwm   = 0;
            m_pos   = 0;
            m_up    = 1;
            m_led   = '0;
            m_step  = 0;
            for (int k = 0; k < NLEDS; k++) m_lvl[k] = 0;
            return;
        end
        br = 0;
        for (int i = 0; i < NPWM; i++)
            if (((m_pwm >> i) & 1) == 1) br += 1 << (NPWM - 1 - i);
        strobe = pause ? step_now : (m_presc == PER - 1);
        sweep  = (mode == 2'd1) || (mode == 2'd2);
        for (int k = 0; k < NLEDS; k++) begin
            if (m_lvl[k] == MAXL)   m_led[k] = 1;
            else if (m_lvl[k] == 0) m_led[k] = 0;
            else                    m_led[k] = (br < m_lvl[k]);
        end
        for (int k = 0; k < NLEDS; k++) begin
            if (mode == 2'd0) m_lvl[k] = 0;
            else if (mode == 2'd3) m_lvl[k] = stat_map[k] ? MAXL : 0;
            else if (strobe) begin
                if (k == m_pos)            m_lvl[k] = MAXL;
                else if (m_lvl[k] > TAIL)  m_lvl[k] = TAIL;
                else if (m_lvl[k] > 0)     m_lvl[k] = m_lvl[k] - 1;
            end
        end
        if (strobe && mode == 2'd1) begin
            if (m_up) begin
                if (m_pos == NLEDS - 1) m_up = 0;
                else                    m_pos++;
            end else begin
                if (m_pos == 0) m_up = 1;
                else            m_pos--;
            end
        end else if (strobe && mode == 2'd2) begin
            m_pos = (m_pos + 1) % NLEDS;
            m_up  = 1;
        end
        m_step = strobe && sweep;
        if (!pause) m_presc = (m_presc + 1) % PER;
        m_pwm = (m_pwm + 1) % (MAXL + 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check("model_owner", owner, 1 << m_pos);
        check("model_step", step, m_step);
        check("model_led", led, m_led);
    endtask

    task automatic wait_step(output int n);
        bit found;
        found = 0;
        n = 0;
        while (!found && n < 64) begin
            tick();
            n++;
            if (step) found = 1;
        end
        if (!found) check("step_timeout", 0, 1);
    endtask

    // Hold pause, let the level settle into o_led, then count o_led[0] highs over one PWM window.
    task automatic measure_led0(output int highs, output int steps);
        highs = 0;
        steps = 0;
        tick();
        tick();
        repeat (MAXL + 1) begin
            tick();
            highs += int'(led[0]);
            steps += int'(step);
        end
    endtask

    int bounce_seq [9] = '{2, 4, 8, 8, 4, 2, 1, 1, 2};
    int fade_owner [5] = '{4, 8, 8, 4, 2};
    int fade_high  [5] = '{4, 3, 2, 1, 0};
    int chase_seq  [4] = '{2, 4, 8, 1};

    initial begin
        int n;
        int highs;
        int steps;

        rst      = 1'b1;
        mode     = 2'd1;
        pause    = 1'b0;
        step_now = 1'b0;
        stat_map = '0;
        tick();
        tick();
        check("rst_led", led, 0);
        check("rst_owner", owner, 1);
        check("rst_step", step, 0);

        rst = 1'b0;
        wait_step(n);
        check("first_step_latency", n, PER);
        check("bounce_0", owner, bounce_seq[0]);
        for (int i = 1; i < 9; i++) begin
            wait_step(n);
            check("bounce_period", n, PER);
            check($sformatf("bounce_%0d", i), owner, bounce_seq[i]);
        end

        pause = 1'b1;
        measure_led0(highs, steps);
        check("pwm_high_max", highs, MAXL + 1);
        check("pause_owner", owner, 2);
        check("pause_no_step", steps, 0);

        for (int i = 0; i < 5; i++) begin
            step_now = 1'b1;
            tick();
            step_now = 1'b0;
            check($sformatf("single_step_%0d", i), step, 1);
            check($sformatf("single_owner_%0d", i), owner, fade_owner[i]);
            measure_led0(highs, steps);
            check($sformatf("fade_high_%0d", i), highs, fade_high[i]);
            check($sformatf("fade_no_extra_step_%0d", i), steps, 0);
        end

        pause    = 1'b0;
        step_now = 1'b1;
        tick();
        step_now = 1'b0;
        check("step_now_unpaused_ignored", step, 0);
        wait_step(n);
        check("resume_latency", n, PER - 1);
        check("resume_owner", owner, 1);

        rst  = 1'b1;
        mode = 2'd2;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            check($sformatf("chase_%0d", i), owner, chase_seq[i]);
        end
        mode = 2'd1;
        wait_step(n);
        check("chase_dir_up", owner, 2);

        mode     = 2'd3;
        stat_map = 4'b1010;
        tick();
        tick();
        check("static_led", led, 4'b1010);
        steps = 0;
        repeat (20) begin
            tick();
            steps += int'(step);
        end
        check("static_no_step", steps, 0);

        mode = 2'd1;
        wait_step(n);
        wait_step(n);
        rst = 1'b1;
        tick();
        check("midreset_owner", owner, 1);
        check("midreset_led", led, 0);
        rst = 1'b0;

        repeat (3000) begin
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) pause = ~pause;
            step_now = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) stat_map = NLEDS'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
